// File: rtl/terminal_rr_arbiter.sv
// rtl/terminal_rr_arbiter.sv - round-robin terminal arbiter with single-entry holding register
// Optional stall watchdog: define ARB_WATCHDOG_EN.
module terminal_rr_arbiter #(
   parameter int N_REQ    = 4,
   parameter int PCK_SZ   = 40,
   parameter int DST_MSB  = 31,
   parameter int DST_LSB  = 26,
   parameter int PORT_ID  = 0,
   parameter int WD_LIMIT = 128
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_REQ-1:0]              req_pndng,
   input  logic [N_REQ-1:0][PCK_SZ-1:0]  req_data,
   output logic [N_REQ-1:0]              req_pop,
   output logic [PCK_SZ-1:0]             out_data,
   output logic                          out_pndng,
   input  logic                          out_pop,
   output logic [15:0]                   drop_cnt,
   output logic                          wd_timeout
);

   localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int DST_W = DST_MSB - DST_LSB + 1;
   localparam logic [DST_W-1:0] PORT_DST = DST_W'(PORT_ID);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [PCK_SZ-1:0]   data_q, data_d;
   logic [15:0]         drop_q, drop_d;

   logic [PW-1:0]       winner;
   logic [PW-1:0]       idx_w;
   logic                found;
   logic                accept;
   logic                grant;
   logic                dst_ok;

   // Scan ptr+1 .. ptr+N_REQ so the last granted requester has lowest priority.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx_w  = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx_w = PW'((int'(ptr_q) + k) % N_REQ);
         if (!found && req_pndng[idx_w]) begin
            found  = 1'b1;
            winner = idx_w;
         end
      end
   end

   assign accept = (state_q == IDLE) || out_pop;
   assign grant  = accept && found;
   assign dst_ok = (req_data[winner][DST_MSB:DST_LSB] == PORT_DST);

   // Gated by reset so no pop can leak out while the block is held in reset.
   assign req_pop = (grant && reset) ? (N_REQ'(1) << winner) : '0;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      drop_d  = drop_q;
      if (state_q == HOLD && out_pop) begin
         state_d = IDLE;
      end
      if (grant) begin
         ptr_d = winner;
         if (dst_ok) begin
            data_d  = req_data[winner];
            state_d = HOLD;
         end else begin
            state_d = IDLE;
            if (drop_q != 16'hFFFF) begin
               drop_d = drop_q + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= PW'(N_REQ - 1);
         data_q  <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         drop_q  <= drop_d;
      end
   end

   assign out_pndng = (state_q == HOLD);
   assign out_data  = data_q;
   assign drop_cnt  = drop_q;

`ifdef ARB_WATCHDOG_EN
   logic [7:0] wd_cnt_q, wd_cnt_d;
   logic       wd_q, wd_d;

   always_comb begin
      wd_cnt_d = '0;
      if (state_q == HOLD && !out_pop) begin
         wd_cnt_d = (wd_cnt_q == 8'hFF) ? wd_cnt_q : wd_cnt_q + 8'd1;
      end
      wd_d = wd_q || (wd_cnt_d == 8'(WD_LIMIT));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_cnt_q <= '0;
         wd_q     <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         wd_q     <= wd_d;
      end
   end

   assign wd_timeout = wd_q;
`else
   assign wd_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_terminal_rr_arbiter.sv
// tb/tb_terminal_rr_arbiter.sv - directed scoreboard bench for terminal_rr_arbiter
module tb_terminal_rr_arbiter;

   logic              clk;
   logic              reset;
   logic [3:0]        req_pndng;
   logic [3:0][39:0]  req_data;
   logic [3:0]        req_pop;
   logic [39:0]       out_data;
   logic              out_pndng;
   logic              out_pop;
   logic [15:0]       drop_cnt;
   logic              wd_timeout;

   int n_tests = 0;
   int n_fail  = 0;
   int seq[4];
   logic [39:0] exp_q[$];
   logic [39:0] held;
   logic        wd_exp;
   logic [3:0]  e_pop;
   int          w;

   terminal_rr_arbiter #(
      .N_REQ(4), .PCK_SZ(40), .DST_MSB(31), .DST_LSB(26), .PORT_ID(0), .WD_LIMIT(128)
   ) dut (
      .clk(clk), .reset(reset), .req_pndng(req_pndng), .req_data(req_data),
      .req_pop(req_pop), .out_data(out_data), .out_pndng(out_pndng), .out_pop(out_pop),
      .drop_cnt(drop_cnt), .wd_timeout(wd_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [39:0] pkt(input int i, input int k, input logic [5:0] d);
      return {8'(i), d, 26'(k)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic peek(input string tag);
      logic [39:0] e;
      e = (exp_q.size() > 0) ? exp_q[0] : 40'hFF_FFFF_FFFF;
      chk(tag, out_data, e);
   endtask

   task automatic consume(input string tag);
      logic [39:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 40'hFF_FFFF_FFFF;
      chk(tag, out_data, e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [5:0] d);
      req_data[i] = pkt(i, seq[i], d);
   endtask

   initial begin
`ifdef ARB_WATCHDOG_EN
      wd_exp = 1'b1;
`else
      wd_exp = 1'b0;
`endif
      for (int i = 0; i < 4; i++) begin
         seq[i] = 0;
         set_req(i, 6'd0);
      end
      reset = 1'b0;
      out_pop = 1'b0;
      req_pndng = 4'b0101;
      #2;
      chk("rst_out_pndng", out_pndng, 1'b0);
      chk("rst_out_data", out_data, 40'h0);
      chk("rst_req_pop", req_pop, 4'b0000);
      chk("rst_drop_cnt", drop_cnt, 16'h0);
      chk("rst_wd", wd_timeout, 1'b0);
      tick();

      // Post-reset first grant
      reset = 1'b1;
      #1;
      chk("first_grant", req_pop, 4'b0001);
      exp_q.push_back(pkt(0, seq[0], 6'd0));
      tick();
      seq[0]++; set_req(0, 6'd0);
      req_pndng = 4'b0100;
      #1;
      chk("first_out_pndng", out_pndng, 1'b1);
      peek("first_out_data");
      chk("first_hold_no_pop", req_pop, 4'b0000);
      out_pop = 1'b1;
      #1;
      chk("second_grant_on_pop", req_pop, 4'b0100);
      consume("first_consume");
      exp_q.push_back(pkt(2, seq[2], 6'd0));
      tick();
      seq[2]++; set_req(2, 6'd0);
      req_pndng = 4'b0000;
      #1;
      chk("second_out_pndng", out_pndng, 1'b1);
      consume("second_consume");
      tick();
      out_pop = 1'b0;
      #1;
      chk("drained", out_pndng, 1'b0);

      // Reset pulse so the round-robin pass starts at requester 0
      reset = 1'b0;
      tick();
      reset = 1'b1;

      // Round-robin and full throughput
      out_pop = 1'b1;
      req_pndng = 4'b1111;
      for (int c = 0; c <= 8; c++) begin
         if (c == 8) req_pndng = 4'b0000;
         #1;
         e_pop = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
         chk("rr_grant", req_pop, e_pop);
         if (c > 0) begin
            chk("rr_out_pndng", out_pndng, 1'b1);
            consume("rr_data");
         end
         w = c % 4;
         if (c < 8) exp_q.push_back(pkt(w, seq[w], 6'd0));
         tick();
         if (c < 8) begin
            seq[w]++; set_req(w, 6'd0);
         end
      end
      chk("rr_drained", out_pndng, 1'b0);

      // Backpressure: ptr is 3, so requester 0 wins next
      out_pop = 1'b0;
      req_pndng = 4'b1111;
      #1;
      chk("bp_grant0", req_pop, 4'b0001);
      exp_q.push_back(pkt(0, seq[0], 6'd0));
      tick();
      seq[0]++; set_req(0, 6'd0);
      held = out_data;
      for (int c = 0; c < 10; c++) begin
         chk("bp_no_pop", req_pop, 4'b0000);
         chk("bp_pndng", out_pndng, 1'b1);
         peek("bp_stable");
         tick();
      end
      out_pop = 1'b1;
      #1;
      chk("bp_release_grant", req_pop, 4'b0010);
      consume("bp_consume");
      exp_q.push_back(pkt(1, seq[1], 6'd0));
      tick();
      seq[1]++; set_req(1, 6'd0);
      req_pndng = 4'b0000;
      #1;
      consume("bp_consume2");
      tick();
      out_pop = 1'b0;

      // Misrouted packet from requester 1 (ptr is 1, so scan reaches 1 last)
      set_req(1, 6'd5);
      req_pndng = 4'b0010;
      #1;
      chk("drop_grant", req_pop, 4'b0010);
      chk("drop_cnt_before", drop_cnt, 16'd0);
      tick();
      seq[1]++; set_req(1, 6'd0);
      req_pndng = 4'b0100;
      #1;
      chk("drop_no_out", out_pndng, 1'b0);
      chk("drop_cnt_after", drop_cnt, 16'd1);
      chk("after_drop_grant", req_pop, 4'b0100);
      exp_q.push_back(pkt(2, seq[2], 6'd0));
      tick();
      seq[2]++; set_req(2, 6'd0);
      req_pndng = 4'b0000;
      #1;
      chk("after_drop_pndng", out_pndng, 1'b1);
      out_pop = 1'b1;
      #1;
      consume("after_drop_data");
      tick();
      out_pop = 1'b0;

      // Watchdog: ptr is 2, requester 0 alone wins
      req_pndng = 4'b0001;
      #1;
      chk("wd_grant", req_pop, 4'b0001);
      exp_q.push_back(pkt(0, seq[0], 6'd0));
      tick();
      seq[0]++; set_req(0, 6'd0);
      req_pndng = 4'b0000;
      for (int c = 0; c < 127; c++) tick();
      chk("wd_before_limit", wd_timeout, 1'b0);
      tick();
      chk("wd_at_limit", wd_timeout, wd_exp);
      out_pop = 1'b1;
      #1;
      consume("wd_consume");
      tick();
      out_pop = 1'b0;
      #1;
      chk("wd_sticky", wd_timeout, wd_exp);

      // Asynchronous reset while holding; ptr is 0 before reset
      req_pndng = 4'b0001;
      tick();
      req_pndng = 4'b1111;
      out_pop = 1'b1;
      #1;
      chk("pre_areset_pndng", out_pndng, 1'b1);
      chk("pre_areset_pop", req_pop, 4'b0010);
      #1;
      reset = 1'b0;
      #1;
      chk("areset_out_pndng", out_pndng, 1'b0);
      chk("areset_req_pop", req_pop, 4'b0000);
      chk("areset_out_data", out_data, 40'h0);
      chk("areset_wd", wd_timeout, 1'b0);
      chk("areset_drop", drop_cnt, 16'h0);
      exp_q.delete();
      out_pop = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      chk("areset_first_grant", req_pop, 4'b0001);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
